// File: rtl/message_pkg.sv
// message_pkg: shared types and constants for the message writer and its button conditioners.
package message_pkg;
    localparam int MSG_DIGITS       = 16;
    localparam int MSG_BITS         = 32;
    localparam int BUF_BITS         = 2 * MSG_BITS;
    localparam int COUNT_BITS       = $clog2(MSG_DIGITS + 1);
    localparam int DEBOUNCE_DEFAULT = 250000;

    typedef logic [3:0] nibble_t;
    typedef enum logic [1:0] {EDIT, FULL, COMMIT} state_t;

    // Digit 0 is the most significant nibble, so digit k starts at bit 4*(15-k).
    function automatic logic [5:0] nibble_lsb(input logic [3:0] idx);
        return {~idx, 2'b00};
    endfunction
endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: 2-flop synchronizer, debounce counter and rising-edge one-shot;
// emits one single-cycle pulse per accepted press.
module button_conditioner import message_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done;

    // Any sample that matches the accepted level restarts the stability window.
    assign done = cnt_q == CW'(DEBOUNCE_CYCLES - 1);

    always_comb begin
        level_d = (sync2_q != level_q && done) ? sync2_q : level_q;
        cnt_d   = (sync2_q == level_q || done) ? '0 : cnt_q + 1'b1;
        pulse_d = level_q & ~level_prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            pulse_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            pulse_q      <= pulse_d;
            cnt_q        <= cnt_d;
        end
    end

    assign pulse = pulse_q;
endmodule

// File: rtl/message_writer.sv
// message_writer: button-driven 16-digit hex entry buffer published as two 32-bit messages.
// Optional entry preview ports hex3..hex0 when MESSAGE_WRITER_ECHO_EN is defined.
module message_writer import message_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            digit_in,
    input  logic                  btn_write,
    input  logic                  btn_commit,
    input  logic                  btn_clear,
    output logic [MSG_BITS-1:0]   message1,
    output logic [MSG_BITS-1:0]   message2,
    output logic                  msg_valid,
    output logic [COUNT_BITS-1:0] count,
    output logic                  full
`ifdef MESSAGE_WRITER_ECHO_EN
    ,
    output logic [3:0]            hex3,
    output logic [3:0]            hex2,
    output logic [3:0]            hex1,
    output logic [3:0]            hex0
`endif
);
    logic                  wr_p, cmt_p, clr_p;
    logic                  wr_accept;
    state_t                state_q, state_d;
    logic [COUNT_BITS-1:0] count_q, count_d;
    logic [BUF_BITS-1:0]   edit_q, edit_d;
    logic [MSG_BITS-1:0]   msg1_q, msg1_d, msg2_q, msg2_d;
    logic                  msg_valid_q, msg_valid_d;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_write (
        .clk(clk), .reset(reset), .btn(btn_write), .pulse(wr_p)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit (
        .clk(clk), .reset(reset), .btn(btn_commit), .pulse(cmt_p)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk(clk), .reset(reset), .btn(btn_clear), .pulse(clr_p)
    );

    // A write only lands in EDIT and only when no higher-priority pulse shares its cycle.
    assign wr_accept = wr_p && !cmt_p && !clr_p && state_q == EDIT;

    always_ff @(posedge clk) begin
        if (reset) state_q <= EDIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = (clr_p || state_q == COMMIT) ? EDIT :
                  cmt_p                         ? COMMIT :
                  (wr_accept && count_q == COUNT_BITS'(MSG_DIGITS - 1)) ? FULL : state_q;
    end

    always_comb begin
        edit_d      = edit_q;
        count_d     = count_q;
        msg1_d      = msg1_q;
        msg2_d      = msg2_q;
        msg_valid_d = 1'b0;
        if (clr_p) begin
            edit_d  = '0;
            count_d = '0;
        end else if (state_q == COMMIT) begin
            msg1_d      = edit_q[BUF_BITS-1 -: MSG_BITS];
            msg2_d      = edit_q[MSG_BITS-1:0];
            msg_valid_d = 1'b1;
            count_d     = '0;
        end else if (wr_accept) begin
            edit_d[nibble_lsb(count_q[3:0]) +: 4] = digit_in;
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            edit_q      <= '0;
            count_q     <= '0;
            msg1_q      <= '0;
            msg2_q      <= '0;
            msg_valid_q <= 1'b0;
        end else begin
            edit_q      <= edit_d;
            count_q     <= count_d;
            msg1_q      <= msg1_d;
            msg2_q      <= msg2_d;
            msg_valid_q <= msg_valid_d;
        end
    end

    assign message1  = msg1_q;
    assign message2  = msg2_q;
    assign msg_valid = msg_valid_q;
    assign count     = count_q;
    assign full      = count_q == COUNT_BITS'(MSG_DIGITS);

`ifdef MESSAGE_WRITER_ECHO_EN
    logic [15:0] echo_q, echo_d;

    always_comb echo_d = clr_p ? '0 : wr_accept ? {echo_q[11:0], digit_in} : echo_q;

    always_ff @(posedge clk) begin
        if (reset) echo_q <= '0;
        else       echo_q <= echo_d;
    end

    assign {hex3, hex2, hex1, hex0} = echo_q;
`endif
endmodule

// File: tb/tb_message_writer.sv
// tb_message_writer: table-driven and randomized checks of message_writer against a digit-array model.
module tb_message_writer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  digit_in = '0;
    logic        btn_write = 1'b0, btn_commit = 1'b0, btn_clear = 1'b0;
    logic [31:0] message1, message2;
    logic        msg_valid, full;
    logic [4:0]  count;
`ifdef MESSAGE_WRITER_ECHO_EN
    logic [3:0]  hex3, hex2, hex1, hex0;
`endif

    int n_checks = 0, n_fail = 0;
    int vld_total = 0, vld_before = 0;

    int          mdig[16];
    int          mcount = 0;
    logic [31:0] mm1 = '0, mm2 = '0;
    int          mhist[$];

    typedef struct {
        int          op;
        logic [3:0]  d;
        logic [4:0]  cnt;
        logic        fl;
        logic [31:0] m1;
        logic [31:0] m2;
        int          vld;
    } vec_t;
    vec_t tbl[13];

    always #5 clk = ~clk;

    message_writer #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .digit_in(digit_in),
        .btn_write(btn_write), .btn_commit(btn_commit), .btn_clear(btn_clear),
        .message1(message1), .message2(message2), .msg_valid(msg_valid),
        .count(count), .full(full)
`ifdef MESSAGE_WRITER_ECHO_EN
        , .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0)
`endif
    );

    always @(negedge clk) if (msg_valid) vld_total++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic void m_write(input int d);
        if (mcount < 16) begin
            mdig[mcount] = d;
            mcount++;
            mhist.push_back(d);
        end
    endfunction

    function automatic void m_commit();
        mm1 = '0;
        mm2 = '0;
        for (int k = 0; k < 8; k++) begin
            mm1 = mm1 * 16 + 32'(mdig[k]);
            mm2 = mm2 * 16 + 32'(mdig[k+8]);
        end
        mcount = 0;
    endfunction

    function automatic void m_clear();
        for (int k = 0; k < 16; k++) mdig[k] = 0;
        mcount = 0;
        mhist.delete();
    endfunction

    function automatic logic [31:0] hist(input int k);
        return (mhist.size() > k) ? 32'(mhist[mhist.size()-1-k]) : 32'h0;
    endfunction

    task automatic press(input logic w, input logic c, input logic k, input logic [3:0] d);
        digit_in = d;
        btn_write = w;
        btn_commit = c;
        btn_clear = k;
        cycles(12);
        btn_write = 1'b0;
        btn_commit = 1'b0;
        btn_clear = 1'b0;
        cycles(12);
    endtask

    task automatic do_op(input int op, input logic [3:0] d);
        vld_before = vld_total;
        if (op == 0) begin press(1, 0, 0, d); m_write(int'(d)); end
        else if (op == 1) begin press(0, 1, 0, d); m_commit(); end
        else begin press(0, 0, 1, d); m_clear(); end
    endtask

    task automatic check_model(input string tag, input int exp_vld);
        chk({tag, " count"}, 32'(count), 32'(mcount));
        chk({tag, " full"}, 32'(full), 32'(mcount == 16));
        chk({tag, " message1"}, message1, mm1);
        chk({tag, " message2"}, message2, mm2);
        chk({tag, " msg_valid cycles"}, 32'(vld_total - vld_before), 32'(exp_vld));
`ifdef MESSAGE_WRITER_ECHO_EN
        chk({tag, " hex0"}, 32'(hex0), hist(0));
        chk({tag, " hex1"}, 32'(hex1), hist(1));
        chk({tag, " hex2"}, 32'(hex2), hist(2));
        chk({tag, " hex3"}, 32'(hex3), hist(3));
`endif
    endtask

    initial begin
        tbl[0]  = '{0, 4'h1, 5'd1, 1'b0, 32'h0, 32'h0, 0};
        tbl[1]  = '{0, 4'h2, 5'd2, 1'b0, 32'h0, 32'h0, 0};
        tbl[2]  = '{0, 4'h3, 5'd3, 1'b0, 32'h0, 32'h0, 0};
        tbl[3]  = '{0, 4'h4, 5'd4, 1'b0, 32'h0, 32'h0, 0};
        tbl[4]  = '{0, 4'h5, 5'd5, 1'b0, 32'h0, 32'h0, 0};
        tbl[5]  = '{0, 4'h6, 5'd6, 1'b0, 32'h0, 32'h0, 0};
        tbl[6]  = '{0, 4'h7, 5'd7, 1'b0, 32'h0, 32'h0, 0};
        tbl[7]  = '{0, 4'h8, 5'd8, 1'b0, 32'h0, 32'h0, 0};
        tbl[8]  = '{1, 4'h0, 5'd0, 1'b0, 32'h12345678, 32'h0, 1};
        tbl[9]  = '{0, 4'h9, 5'd1, 1'b0, 32'h12345678, 32'h0, 0};
        tbl[10] = '{1, 4'h0, 5'd0, 1'b0, 32'h92345678, 32'h0, 1};
        tbl[11] = '{2, 4'h0, 5'd0, 1'b0, 32'h92345678, 32'h0, 0};
        tbl[12] = '{1, 4'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1};
        m_clear();

        cycles(3);
        reset = 1'b0;
        cycles(1);
        chk("reset count", 32'(count), 32'h0);
        chk("reset full", 32'(full), 32'h0);
        chk("reset message1", message1, 32'h0);
        chk("reset message2", message2, 32'h0);
        chk("reset msg_valid", 32'(msg_valid), 32'h0);

        for (int i = 0; i < 13; i++) begin
            do_op(tbl[i].op, tbl[i].d);
            chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d full", i), 32'(full), 32'(tbl[i].fl));
            chk($sformatf("vec%0d message1", i), message1, tbl[i].m1);
            chk($sformatf("vec%0d message2", i), message2, tbl[i].m2);
            chk($sformatf("vec%0d msg_valid cycles", i), 32'(vld_total - vld_before), 32'(tbl[i].vld));
        end

        // Fill all 16 digits, then one extra write that must be ignored.
        for (int i = 0; i < 16; i++) begin
            do_op(0, 4'(i));
            check_model($sformatf("fill%0d", i), 0);
        end
        do_op(0, 4'hA);
        chk("overflow count", 32'(count), 32'd16);
        chk("overflow full", 32'(full), 32'h1);
        check_model("overflow", 0);
        do_op(1, 4'h0);
        chk("full commit message1", message1, 32'h01234567);
        chk("full commit message2", message2, 32'h89ABCDEF);
        check_model("full commit", 1);

        // Bouncy write: 2-cycle toggles never survive a 4-cycle window.
        do_op(2, 4'h0);
        vld_before = vld_total;
        digit_in = 4'h5;
        for (int i = 0; i < 5; i++) begin
            btn_write = 1'b1;
            cycles(2);
            btn_write = 1'b0;
            cycles(2);
        end
        btn_write = 1'b1;
        cycles(12);
        btn_write = 1'b0;
        cycles(12);
        m_write(5);
        chk("bounce count", 32'(count), 32'd1);
        check_model("bounce", 0);

        // Clear and commit in the same cycle: clear wins, no publish.
        do_op(0, 4'h3);
        do_op(0, 4'hC);
        do_op(0, 4'hE);
        vld_before = vld_total;
        press(0, 1, 1, 4'h0);
        m_clear();
        chk("clr+cmt count", 32'(count), 32'd0);
        chk("clr+cmt message1", message1, 32'h01234567);
        check_model("clr+cmt", 0);
        do_op(1, 4'h0);
        chk("cleared buffer message1", message1, 32'h0);
        check_model("cleared buffer", 1);

        // Reset the cycle after a commit pulse aborts the publish.
        do_op(0, 4'h7);
        do_op(1, 4'h0);
        check_model("pre-reset", 1);
        do_op(0, 4'h1);
        do_op(0, 4'h2);
        vld_before = vld_total;
        @(negedge clk);
        btn_commit = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        btn_commit = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cycles(15);
        m_clear();
        mm1 = '0;
        mm2 = '0;
        chk("abort message1", message1, 32'h0);
        check_model("abort", 0);
        do_op(0, 4'h6);
        check_model("after abort write", 0);

`ifdef MESSAGE_WRITER_ECHO_EN
        do_op(2, 4'h0);
        do_op(0, 4'h9);
        do_op(0, 4'h4);
        do_op(0, 4'h7);
        chk("echo hex3", 32'(hex3), 32'h0);
        chk("echo hex2", 32'(hex2), 32'h9);
        chk("echo hex1", 32'(hex1), 32'h4);
        chk("echo hex0", 32'(hex0), 32'h7);
        do_op(2, 4'h0);
        chk("echo cleared", 32'({hex3, hex2, hex1, hex0}), 32'h0);
`endif

        for (int i = 0; i < 30; i++) begin
            int r;
            int op;
            r = int'($urandom_range(0, 9));
            op = (r < 6) ? 0 : (r < 8) ? 1 : 2;
            do_op(op, 4'($urandom_range(0, 15)));
            check_model($sformatf("rand%0d", i), (op == 1) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/message_writer.md
# message_writer

Operator-side entry block that builds the two 32-bit scroll messages consumed by the display scroller and the four-digit LED driver. A hex digit set on switches is committed nibble by nibble with debounced push-buttons into a 16-nibble edit buffer. An explicit commit copies the buffer to the `message1`/`message2` outputs. This block is the writer of the message interface that the scroller reads.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: number of consecutive stable sampled cycles required before a button level is accepted.
- `clk` input, 1 bit: single system clock; all logic on rising edge.
- `reset` input, 1 bit: synchronous, active-high; sampled on rising `clk`.
- `digit_in` input, 4 bits: hex digit from switches; sampled on the write-accept cycle.
- `btn_write` input, 1 bit: raw, asynchronous push-button; appends `digit_in`.
- `btn_commit` input, 1 bit: raw push-button; publishes the buffer.
- `btn_clear` input, 1 bit: raw push-button; empties the buffer.
- `message1` output, 32 bits: digits 0–7; digit k occupies `[31-4k:28-4k]`.
- `message2` output, 32 bits: digits 8–15, same packing.
- `msg_valid` output, 1 bit: one-cycle pulse when `message1`/`message2` update.
- `count` output, 5 bits: digits written since last clear/commit, 0–16.
- `full` output, 1 bit: high when `count == 16`.

## Operation
- Each raw button passes through a 2-flop synchronizer, then a debounce counter, then a rising-edge one-shot. The result is one 1-cycle pulse per accepted press.
- Edit buffer: 64 bits, reset to 0. A write stores `digit_in` at nibble index `count[3:0]`, then `count` increments.
- FSM states:
  - EDIT: write pulse stores the digit. If `count` becomes 16, next state is FULL.
  - FULL: write pulses are ignored; buffer and `count` are unchanged.
  - COMMIT: one cycle. `message1 <= buf[63:32]`, `message2 <= buf[31:0]`, `msg_valid` = 1, `count <= 0`, buffer retained. Next state is EDIT.
- Commit pulse in EDIT or FULL → COMMIT. A commit with `count == 0` is allowed and republishes the buffer unchanged.
- Clear pulse in any state → EDIT. Buffer is zeroed and `count` is 0. `message1`/`message2` are untouched.
- Priority for pulses in the same cycle: clear > commit > write. Lower-priority pulses in that cycle are discarded.
- Write pulses arriving while in COMMIT are discarded.
- After a commit, new writes overwrite from digit 0. Untouched later digits keep their old values until the next clear.

## Timing
- Reset values:
  - `message1` = `message2` = 0
  - `msg_valid` = 0, `count` = 0, `full` = 0
  - state = EDIT
  - synchronizers, debounce counters and one-shots = 0
- Reset asserted mid-debounce or in COMMIT aborts the operation. No `msg_valid` pulse is produced.
- Button latency: raw edge → pulse takes 2 synchronizer cycles + `DEBOUNCE_CYCLES` cycles + 1 cycle. Any bounce inside the window restarts the counter.
- Write pulse in cycle N: the buffer nibble and `count` update at edge N+1. `full` rises at the same edge when `count` reaches 16.
- Commit pulse in cycle N: COMMIT state in N+1. `message1`/`message2` and `msg_valid` are registered and visible in N+2. `msg_valid` is low again in N+3.
- Holding a button produces exactly one pulse. Releasing it is also debounced.

## Configuration
- `MESSAGE_WRITER_ECHO_EN`
  - Defined: adds output ports `hex3`, `hex2`, `hex1`, `hex0` (4 bits each, reset 0), registered from the last four written buffer nibbles. `hex0` is the most recent digit; a position with no digit yet reads 0. Clear zeroes them. These ports feed the LED driver directly for entry preview.
  - Undefined: the ports and their registers do not exist; all other behaviour is identical.

## Structure
- Shared package `message_pkg`:
  - nibble typedef
  - FSM state enum (EDIT, FULL, COMMIT)
  - `MSG_DIGITS` = 16
  - default `DEBOUNCE_CYCLES` constant
  - message packing helper constants
- Sub-module `button_conditioner`: synchronizer + debounce + one-shot, parameterized by `DEBOUNCE_CYCLES`, instantiated three times.

## Test plan (`DEBOUNCE_CYCLES` = 4)
- Reset, then write digits 1..8 with clean presses, then commit → `message1` = 0x12345678, `message2` = 0, `msg_valid` high exactly one cycle, `count` = 0.
- Write 17 digits 0x0–0xF then 0xA → `full` = 1 after the 16th, 17th ignored; commit → `message1` = 0x01234567, `message2` = 0x89ABCDEF.
- Bouncy `btn_write` toggling every 2 cycles for 20 cycles, then stable high → exactly one write, `count` = 1.
- Clear and commit pulses in the same cycle after 3 writes → buffer 0, `count` = 0, no `msg_valid`, messages unchanged.
- Reset asserted the cycle after a commit pulse → no `msg_valid`, messages = 0, state EDIT.
- With `MESSAGE_WRITER_ECHO_EN`: write 0x9, 0x4, 0x7 → `hex3..hex0` = 0, 9, 4, 7; clear → all 0.
